uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver stage of the UART, sitting directly upstream of the receive one-word buffer.
- Samples the asynchronous rx line using 16x oversampling ticks from the baud-rate generator.
- Reassembles one LSB-first frame of start, data, optional parity and stop bits.
- Presents the word on dout with a one-clock rx_done_tick, which drives the buffer's set_flag.
- Also reports framing and parity errors.

Parameters:
- DBIT, 8: number of data bits per frame (supported 5..8).
- SB_TICK, 16: oversampling ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clock  input  1  main system clock, 50 MHz.
- reset  input  1  asynchronous active-low reset.
- s_tick  input  1  one-clock-wide pulse at 16x the baud rate, from the baud generator.
- rx  input  1  asynchronous serial input; idle level is high.
- dout  output  8  received word, LSB-aligned; unused upper bits are 0 when DBIT < 8.
- rx_done_tick  output  1  one-clock pulse when a frame completes; connects to the buffer's set_flag.
- frame_err  output  1  stop bit was sampled low in the last frame.
- parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY_EN = 0.

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on posedge clock.
  - reset low, asynchronously: FSM goes to IDLE, counters clear to 0, shift register clears to 0.
  - Output reset values: dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, synchronizer flops = 1.
  - Reset mid-frame abandons the frame; no rx_done_tick is generated.
- Input synchronizer
  - rx passes through a 2-flop synchronizer to give rx_s; the FSM uses only rx_s.
- Counters
  - s: 5-bit tick counter.
  - n: 3-bit bit counter.
  - Both advance only in cycles where s_tick = 1; cycles without s_tick hold all state.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when armed = 1 and rx_s = 0, go to START with s = 0. armed sets when rx_s = 1 is seen in IDLE.
  - START: on s_tick with s == 7 (mid start bit):
    - if rx_s = 0, go to DATA with s = 0, n = 0;
    - else go to IDLE (glitch rejection, no output).
    - Otherwise s++.
  - DATA: on s_tick with s == 15:
    - s = 0; shift register b = {rx_s, b[7:1]};
    - if n == DBIT-1, go to PARITY if PARITY_EN, else STOP; otherwise n++.
  - PARITY: on s_tick with s == 15:
    - s = 0; capture p_err = (^data bits) ^ rx_s ^ PARITY_ODD;
    - go to STOP.
  - STOP: on s_tick with s == SB_TICK-1, in the same clock edge:
    - dout <= b right-justified to DBIT bits;
    - frame_err <= ~rx_s;
    - parity_err <= p_err;
    - rx_done_tick <= 1 for exactly one clock;
    - go to IDLE;
    - armed <= rx_s, so a held-low break line cannot retrigger until rx returns high.
- Outputs
  - rx_done_tick is asserted even on a framing or parity error; error flags are valid in the same cycle.
  - dout, frame_err and parity_err hold their values until the next rx_done_tick.
- Latency
  - rx_done_tick occurs about (8 + 16*DBIT + 16*PARITY_EN + SB_TICK) ticks after the falling edge, plus 2-3 clocks of synchronizer delay.
- Boundary conditions
  - s_tick asserted on consecutive clocks is legal; each one counts.
  - Back-to-back frames: a start edge arriving in the first IDLE cycle is accepted.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - OVERSAMPLE = 16;
  - stop-bit tick constants SB_1 = 16, SB_1_5 = 24, SB_2 = 32.
  - The same file is used by the transmitter and the baud generator.
- Sub-module sync_2ff: 1-bit two-flop synchronizer with reset value 1; reusable for other asynchronous inputs.

Test Plan:
- Common setup for all scenarios: s_tick every 4 clocks; 16 ticks per bit; PARITY_EN = 0 unless noted.
- Normal frame: send 0xA5 with 1 stop bit -> exactly one rx_done_tick; dout = 0xA5; frame_err = 0; parity_err = 0.
- Start glitch: rx low for 4 ticks then high, for 400 clocks -> no rx_done_tick; FSM back in IDLE; dout unchanged (0x00).
- Framing error and break: send 0x3C with stop bit low, then hold rx low for 300 ticks -> one rx_done_tick; dout = 0x3C; frame_err = 1; no further rx_done_tick until rx goes high and a new frame is sent.
- Parity (PARITY_EN = 1, even): send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1; dout = 0x07 in both cases.
- Reset mid-frame: assert reset during the 4th data bit of 0xFF, release, then send 0x12 -> all outputs 0 during reset; first rx_done_tick after release carries dout = 0x12.
- Back-to-back: 0x55 immediately followed by 0xAA, with no idle gap after the stop bit -> two rx_done_tick pulses, dout = 0x55 then 0xAA, no errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, oversampling rate and stop-bit
// tick counts, plus a helper that right-justifies the receive shift register.
// The transmitter and baud generator use the same constants.
package uart_rx_pkg;

  localparam int OVERSAMPLE = 16;

  // Oversampling ticks spent in the stop period.
  localparam int SB_1   = 16;  // 1 stop bit
  localparam int SB_1_5 = 24;  // 1.5 stop bits
  localparam int SB_2   = 32;  // 2 stop bits

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Data bits are shifted in from the top, LSB first, so after dbit shifts
  // the word occupies b[7 -: dbit]. Shifting down drops any stale low bits
  // left from a previous frame and zero-fills the unused upper bits.
  function automatic logic [7:0] right_justify(input logic [7:0] b, input int dbit);
    return b >> (8 - dbit);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus between the baud generator / rx pin and the receive
// buffer.
//   s_tick       : 16x baud oversampling pulse
//   rx           : asynchronous serial line, idle high
//   dout         : received word, LSB-aligned
//   rx_done_tick : one-clock frame-complete pulse (buffer set_flag)
//   frame_err    : stop bit sampled low in the last frame
//   parity_err   : parity mismatch in the last frame
// master drives the line and ticks; slave is the receiver.
interface uart_rx_if;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  modport master (output s_tick, rx, input dout, rx_done_tick, frame_err, parity_err);
  modport slave  (input s_tick, rx, output dout, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer for an asynchronous input.
// Both flops reset to 1 so an idle-high line never shows a false edge.
//   clock : system clock
//   reset : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the two stages into one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver. Reassembles one LSB-first frame
// (start, DBIT data, optional parity, stop) and presents it with a
// one-clock rx_done_tick plus framing and parity error flags.
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   rx_bus : slave side of uart_rx_if (s_tick, rx in; dout, flags out)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT       = 8,     // 5..8
  parameter int SB_TICK    = SB_1,  // 16, 24 or 32
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.slave rx_bus
);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;         // oversampling tick counter
  logic [2:0]  n_q, n_d;         // data bit counter
  logic [7:0]  b_q, b_d;         // receive shift register
  logic        armed_q, armed_d; // line seen high since the last frame
  logic        p_err_q, p_err_d;
  logic [7:0]  dout_q, dout_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        done_q, done_d;
  logic [7:0]  data_w;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (rx_bus.rx),
    .q_o   (rx_s)
  );

  assign data_w = right_justify(b_q, DBIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      armed_q      <= 1'b0;
      p_err_q      <= 1'b0;
      dout_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      armed_q      <= armed_d;
      p_err_q      <= p_err_d;
      dout_q       <= dout_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value before the case so no
    // path leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    armed_d      = armed_q;
    p_err_d      = p_err_q;
    dout_d       = dout_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: if (rx_bus.s_tick) begin
        if (s_q == 5'd7) begin
          // Middle of the start bit: a line back high here was a glitch.
          if (!rx_s) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + 5'd1;
        end
      end
      DATA: if (rx_bus.s_tick) begin
        if (s_q == 5'd15) begin
          s_d = '0;
          b_d = {rx_s, b_q[7:1]};
          if (n_q == 3'(DBIT - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                     n_d = n_q + 3'd1;
        end else begin
          s_d = s_q + 5'd1;
        end
      end
      PARITY: if (rx_bus.s_tick) begin
        if (s_q == 5'd15) begin
          s_d     = '0;
          p_err_d = (^data_w) ^ rx_s ^ 1'(PARITY_ODD);
          state_d = STOP;
        end else begin
          s_d = s_q + 5'd1;
        end
      end
      STOP: if (rx_bus.s_tick) begin
        if (s_q == 5'(SB_TICK - 1)) begin
          dout_d       = data_w;
          frame_err_d  = ~rx_s;
          parity_err_d = p_err_q;
          done_d       = 1'b1;
          state_d      = IDLE;
          // A line still low (break) must return high before re-arming.
          armed_d      = rx_s;
        end else begin
          s_d = s_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_bus.dout         = dout_q;
  assign rx_bus.rx_done_tick = done_q;
  assign rx_bus.frame_err    = frame_err_q;
  assign rx_bus.parity_err   = parity_err_q;

endmodule
